// File: rtl/gmem_rd_arbiter.sv
// -----------------------------------------------------------------------------
// gmem_rd_arbiter
//
// Round-robin arbiter that shares one AXI4 read port (AR/R channels) of the
// kernel's gmem master among NUM_PORTS internal read requesters.
//
// The winning request is captured in a single AR output register. Its port
// index is pushed into an in-order tag FIFO. All bursts use one AXI ID, so
// bursts return in issue order. The FIFO head therefore names the port that
// owns the current R beat, and the R channel is steered combinationally.
//
// Ports
//   ap_clk, ap_rst_n       clock, synchronous active-low reset
//   req_arvalid/arready    per-port request / one-hot grant (same cycle)
//   req_araddr/arlen       packed per-port address and burst length
//   req_rvalid/rready      per-port R handshake, steered to the FIFO head
//   req_rdata/rlast        R payload broadcast to every port
//   m_axi_gmem_AR*         registered AR channel towards gmem
//   m_axi_gmem_R*          R channel from gmem
//   outstanding            bursts granted whose last beat is not yet accepted
// -----------------------------------------------------------------------------
module gmem_rd_arbiter #(
   parameter int NUM_PORTS       = 4,
   parameter int ADDR_WIDTH      = 42,
   parameter int DATA_WIDTH      = 512,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                            ap_clk,
   input  logic                            ap_rst_n,
   input  logic [NUM_PORTS-1:0]            req_arvalid,
   output logic [NUM_PORTS-1:0]            req_arready,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_araddr,
   input  logic [NUM_PORTS*8-1:0]          req_arlen,
   output logic [NUM_PORTS-1:0]            req_rvalid,
   input  logic [NUM_PORTS-1:0]            req_rready,
   output logic [DATA_WIDTH-1:0]           req_rdata,
   output logic                            req_rlast,
   output logic                            m_axi_gmem_ARVALID,
   input  logic                            m_axi_gmem_ARREADY,
   output logic [ADDR_WIDTH-1:0]           m_axi_gmem_ARADDR,
   output logic [7:0]                      m_axi_gmem_ARLEN,
   output logic [2:0]                      m_axi_gmem_ARSIZE,
   output logic [0:0]                      m_axi_gmem_ARID,
   input  logic                            m_axi_gmem_RVALID,
   output logic                            m_axi_gmem_RREADY,
   input  logic [DATA_WIDTH-1:0]           m_axi_gmem_RDATA,
   input  logic                            m_axi_gmem_RLAST,
   output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

   localparam int IDX_W = $clog2(NUM_PORTS);
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;

   // AR output slot
   logic                  ar_valid_q;
   logic [ADDR_WIDTH-1:0] ar_addr_q;
   logic [7:0]            ar_len_q;

   // Arbitration
   logic [IDX_W-1:0]      last_grant_q;
   logic [IDX_W-1:0]      winner;
   logic [IDX_W:0]        cand;
   logic                  found;
   logic                  slot_free;
   logic                  room;
   logic                  grant;

   // In-order tag FIFO
   logic [IDX_W-1:0]      order_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [IDX_W-1:0]      head;
   logic                  fifo_empty;
   logic                  pop;

   assign head       = order_mem[rd_ptr_q];
   assign fifo_empty = (count_q == '0);

   // ---------------------------------------------------------------------------
   // R steering: pure combinational passthrough to the owner of the head burst.
   // ---------------------------------------------------------------------------
   assign req_rdata         = m_axi_gmem_RDATA;
   assign req_rlast         = m_axi_gmem_RLAST;
   assign m_axi_gmem_RREADY = !fifo_empty && req_rready[head];
   assign pop               = m_axi_gmem_RVALID && m_axi_gmem_RREADY && m_axi_gmem_RLAST;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      req_rvalid = '0;
      if (!fifo_empty && m_axi_gmem_RVALID) req_rvalid[head] = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Arbitration: first requester after last_grant, wrapping around.
   // ---------------------------------------------------------------------------
   always_comb begin
      winner = last_grant_q;
      found  = 1'b0;
      cand   = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_PORTS)) cand = cand - (IDX_W+1)'(NUM_PORTS);
         if (!found && req_arvalid[cand[IDX_W-1:0]]) begin
            winner = cand[IDX_W-1:0];
            found  = 1'b1;
         end
      end
   end

   // The slot can be reloaded in the cycle it is accepted, and a pop in the
   // same cycle frees an order-FIFO entry, so both are counted as free here.
   assign slot_free = !ar_valid_q || m_axi_gmem_ARREADY;
   assign room      = (count_q < CNT_W'(MAX_OUTSTANDING)) || pop;
   // No grant while reset is held: a requester must not see an accept that
   // the reset is about to discard.
   assign grant     = ap_rst_n && slot_free && room && found;

   always_comb begin
      req_arready = '0;
      if (grant) req_arready[winner] = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   always_ff @(posedge ap_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!ap_rst_n) begin
         ar_valid_q   <= 1'b0;
         ar_addr_q    <= '0;
         ar_len_q     <= '0;
         last_grant_q <= IDX_W'(NUM_PORTS - 1);
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         if (grant) begin
            ar_valid_q   <= 1'b1;
            ar_addr_q    <= req_araddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            ar_len_q     <= req_arlen[winner*8 +: 8];
            last_grant_q <= winner;
            wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
         end else if (m_axi_gmem_ARREADY) begin
            ar_valid_q <= 1'b0;
         end

         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

         case ({grant, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the tag storage is deliberately not reset; validity is carried by
   // count_q and the pointers, so stale entries are never read.
   always_ff @(posedge ap_clk) begin
      if (grant) order_mem[wr_ptr_q] <= winner;
   end

   assign m_axi_gmem_ARVALID = ar_valid_q;
   assign m_axi_gmem_ARADDR  = ar_addr_q;
   assign m_axi_gmem_ARLEN   = ar_len_q;
   assign m_axi_gmem_ARSIZE  = 3'($clog2(DATA_WIDTH/8));
   assign m_axi_gmem_ARID    = 1'b0;
   assign outstanding        = count_q;

endmodule

// File: tb/tb_gmem_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gmem_rd_arbiter
//
// Self-checking bench for gmem_rd_arbiter (4 ports, 4 bursts in flight).
// Directed scenarios cover reset, a single burst, round-robin fairness, AR
// backpressure, the full condition, R ordering with stalls and a mid-run
// reset. A randomized run compares every cycle against a queue-based
// reference model of the arbitration and return-order rules.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_gmem_rd_arbiter;

   localparam int NP = 4;
   localparam int AW = 42;
   localparam int DW = 512;
   localparam int MO = 4;
   localparam int CW = $clog2(MO) + 1;

   logic             ap_clk = 1'b0;
   logic             ap_rst_n;
   logic [NP-1:0]    req_arvalid;
   logic [NP-1:0]    req_arready;
   logic [NP*AW-1:0] req_araddr;
   logic [NP*8-1:0]  req_arlen;
   logic [NP-1:0]    req_rvalid;
   logic [NP-1:0]    req_rready;
   logic [DW-1:0]    req_rdata;
   logic             req_rlast;
   logic             arvalid;
   logic             arready;
   logic [AW-1:0]    araddr;
   logic [7:0]       arlen;
   logic [2:0]       arsize;
   logic [0:0]       arid;
   logic             rvalid;
   logic             rready;
   logic [DW-1:0]    rdata;
   logic             rlast;
   logic [CW-1:0]    outstanding;

   logic [AW-1:0]    addr_a [NP];
   logic [7:0]       len_a  [NP];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < NP; g++) begin : g_pack
      assign req_araddr[g*AW +: AW] = addr_a[g];
      assign req_arlen[g*8 +: 8]    = len_a[g];
   end

   always #5 ap_clk = ~ap_clk;

   gmem_rd_arbiter #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .req_arvalid(req_arvalid), .req_arready(req_arready),
      .req_araddr(req_araddr), .req_arlen(req_arlen),
      .req_rvalid(req_rvalid), .req_rready(req_rready),
      .req_rdata(req_rdata), .req_rlast(req_rlast),
      .m_axi_gmem_ARVALID(arvalid), .m_axi_gmem_ARREADY(arready),
      .m_axi_gmem_ARADDR(araddr), .m_axi_gmem_ARLEN(arlen),
      .m_axi_gmem_ARSIZE(arsize), .m_axi_gmem_ARID(arid),
      .m_axi_gmem_RVALID(rvalid), .m_axi_gmem_RREADY(rready),
      .m_axi_gmem_RDATA(rdata), .m_axi_gmem_RLAST(rlast),
      .outstanding(outstanding)
   );

   typedef struct packed {
      logic [2:0]    port;
      logic [AW-1:0] addr;
      logic [7:0]    len;
   } burst_t;

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic idle();
      req_arvalid = '0;
      req_rready  = '0;
      arready     = 1'b0;
      rvalid      = 1'b0;
      rdata       = '0;
      rlast       = 1'b0;
      for (int p = 0; p < NP; p++) begin
         addr_a[p] = '0;
         len_a[p]  = '0;
      end
   endtask

   task automatic reset_dut();
      idle();
      ap_rst_n = 1'b0;
      tick();
      tick();
      ap_rst_n = 1'b1;
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
      return d;
   endfunction

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      idle();
      ap_rst_n    = 1'b0;
      req_arvalid = '1;
      rvalid      = 1'b1;
      req_rready  = '1;
      tick();
      tick();
      @(negedge ap_clk);
      checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
      checks++; if (araddr !== '0) begin errors++; $display("FAIL reset_araddr: got %h want 0", araddr); end
      checks++; if (arlen !== 8'd0) begin errors++; $display("FAIL reset_arlen: got %0d want 0", arlen); end
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
      checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", rready); end
      checks++; if (req_rvalid !== 4'b0000) begin errors++; $display("FAIL reset_req_rvalid: got %b want 0000", req_rvalid); end
      checks++; if (req_arready !== 4'b0000) begin errors++; $display("FAIL reset_req_arready: got %b want 0000", req_arready); end
      checks++; if (arsize !== 3'd6) begin errors++; $display("FAIL arsize: got %0d want 6", arsize); end
      checks++; if (arid !== 1'b0) begin errors++; $display("FAIL arid: got %b want 0", arid); end
      tick();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_single();
      reset_dut();
      addr_a[2]   = 42'h1000;
      len_a[2]    = 8'd3;
      req_arvalid = 4'b0100;
      arready     = 1'b1;
      req_rready  = '1;
      @(negedge ap_clk);
      checks++; if (req_arready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_arready); end
      checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_latency: got arvalid %b want 0", arvalid); end
      tick();
      req_arvalid = '0;
      @(negedge ap_clk);
      checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid: got %b want 1", arvalid); end
      checks++; if (araddr !== 42'h1000) begin errors++; $display("FAIL single_araddr: got %h want 1000", araddr); end
      checks++; if (arlen !== 8'd3) begin errors++; $display("FAIL single_arlen: got %0d want 3", arlen); end
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding: got %0d want 1", outstanding); end
      tick();
      for (int b = 0; b < 4; b++) begin
         rvalid = 1'b1;
         rdata  = rand_data();
         rlast  = (b == 3);
         @(negedge ap_clk);
         checks++; if (req_rvalid !== 4'b0100) begin errors++; $display("FAIL single_rvalid beat %0d: got %b want 0100", b, req_rvalid); end
         checks++; if (req_rdata !== rdata || req_rlast !== rlast) begin errors++; $display("FAIL single_rdata beat %0d: got last %b want %b", b, req_rlast, rlast); end
         checks++; if (rready !== 1'b1) begin errors++; $display("FAIL single_rready beat %0d: got %b want 1", b, rready); end
         checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outst beat %0d: got %0d want 1", b, outstanding); end
         tick();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      @(negedge ap_clk);
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_drained: got %0d want 0", outstanding); end
      checks++; if (rready !== 1'b0) begin errors++; $display("FAIL single_empty_rready: got %b want 0", rready); end
      tick();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_fairness();
      reset_dut();
      for (int p = 0; p < NP; p++) addr_a[p] = AW'(32'h100 * (p + 1));
      req_arvalid = '1;
      arready     = 1'b1;
      req_rready  = '1;
      rvalid      = 1'b1;
      rlast       = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge ap_clk);
         checks++; if (req_arready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL fair_grant cycle %0d: got %b want %b", k, req_arready, 4'b0001 << (k % 4)); end
         if (k > 0) begin
            checks++; if (req_rvalid !== (4'b0001 << ((k - 1) % 4))) begin errors++; $display("FAIL fair_route cycle %0d: got %b want %b", k, req_rvalid, 4'b0001 << ((k - 1) % 4)); end
         end
         tick();
      end
      idle();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_backpressure();
      reset_dut();
      addr_a[0]   = 42'h2A0_0000_0040;
      addr_a[1]   = 42'h155_0000_0080;
      req_arvalid = 4'b0011;
      arready     = 1'b0;
      @(negedge ap_clk);
      checks++; if (req_arready !== 4'b0001) begin errors++; $display("FAIL bp_first: got %b want 0001", req_arready); end
      tick();
      req_arvalid = 4'b0010;
      for (int c = 0; c < 5; c++) begin
         @(negedge ap_clk);
         checks++; if (req_arready !== 4'b0000) begin errors++; $display("FAIL bp_hold_grant cycle %0d: got %b want 0000", c, req_arready); end
         checks++; if (arvalid !== 1'b1 || araddr !== addr_a[0]) begin errors++; $display("FAIL bp_hold_addr cycle %0d: got %b/%h want 1/%h", c, arvalid, araddr, addr_a[0]); end
         tick();
      end
      arready = 1'b1;
      @(negedge ap_clk);
      checks++; if (req_arready !== 4'b0010) begin errors++; $display("FAIL bp_release: got %b want 0010", req_arready); end
      tick();
      req_arvalid = '0;
      @(negedge ap_clk);
      checks++; if (arvalid !== 1'b1 || araddr !== addr_a[1]) begin errors++; $display("FAIL bp_second_addr: got %b/%h want 1/%h", arvalid, araddr, addr_a[1]); end
      tick();
      idle();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_full();
      int grants;
      reset_dut();
      grants = 0;
      req_arvalid = '1;
      arready     = 1'b1;
      req_rready  = '1;
      for (int k = 0; k < 8; k++) begin
         @(negedge ap_clk);
         if (req_arready != 0) grants++;
         if (k < 4) begin
            checks++; if (req_arready !== (4'b0001 << k)) begin errors++; $display("FAIL full_grant cycle %0d: got %b want %b", k, req_arready, 4'b0001 << k); end
         end else begin
            checks++; if (req_arready !== 4'b0000 || outstanding !== 3'd4) begin errors++; $display("FAIL full_stop cycle %0d: got %b/%0d want 0000/4", k, req_arready, outstanding); end
         end
         tick();
      end
      checks++; if (grants != 4) begin errors++; $display("FAIL full_count: got %0d want 4", grants); end
      rvalid = 1'b1;
      rlast  = 1'b1;
      @(negedge ap_clk);
      checks++; if (rready !== 1'b1 || req_rvalid !== 4'b0001) begin errors++; $display("FAIL full_pop_route: got %b/%b want 1/0001", rready, req_rvalid); end
      checks++; if (req_arready !== 4'b0001) begin errors++; $display("FAIL full_pop_grant: got %b want 0001", req_arready); end
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
      @(negedge ap_clk);
      checks++; if (outstanding !== 3'd4 || req_arready !== 4'b0000) begin errors++; $display("FAIL full_after_pop: got %0d/%b want 4/0000", outstanding, req_arready); end
      tick();
      idle();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_order();
      burst_t bursts [3];
      int     route [$];
      bit     lasts [$];
      int     left;
      reset_dut();
      bursts[0] = '{port: 3'd3, addr: 42'hA00, len: 8'd1};
      bursts[1] = '{port: 3'd1, addr: 42'hB00, len: 8'd0};
      bursts[2] = '{port: 3'd3, addr: 42'hC00, len: 8'd2};
      arready    = 1'b1;
      req_rready = '1;
      for (int i = 0; i < 3; i++) begin
         req_arvalid = '0;
         req_arvalid[bursts[i].port] = 1'b1;
         addr_a[bursts[i].port] = bursts[i].addr;
         len_a[bursts[i].port]  = bursts[i].len;
         @(negedge ap_clk);
         checks++; if (req_arready !== req_arvalid) begin errors++; $display("FAIL order_grant %0d: got %b want %b", i, req_arready, req_arvalid); end
         tick();
      end
      req_arvalid = '0;
      for (int i = 0; i < 3; i++)
         for (int b = 0; b <= int'(bursts[i].len); b++) begin
            route.push_back(int'(bursts[i].port));
            lasts.push_back(b == int'(bursts[i].len));
         end
      left = 3;
      foreach (route[j]) begin
         rvalid = 1'b1;
         rdata  = rand_data();
         rlast  = lasts[j];
         if (route[j] == 1) begin
            req_rready[1] = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge ap_clk);
               checks++; if (rready !== 1'b0 || req_rvalid !== 4'b0010 || outstanding !== 3'(left)) begin errors++; $display("FAIL order_stall %0d: got %b/%b/%0d want 0/0010/%0d", s, rready, req_rvalid, outstanding, left); end
               tick();
            end
            req_rready[1] = 1'b1;
         end
         @(negedge ap_clk);
         checks++; if (req_rvalid !== (4'b0001 << route[j]) || rready !== 1'b1) begin errors++; $display("FAIL order_route beat %0d: got %b/%b want %b/1", j, req_rvalid, rready, 4'b0001 << route[j]); end
         checks++; if (req_rdata !== rdata || req_rlast !== rlast || outstanding !== 3'(left)) begin errors++; $display("FAIL order_payload beat %0d: got last %b outst %0d want %b/%0d", j, req_rlast, outstanding, rlast, left); end
         tick();
         if (lasts[j]) left--;
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      @(negedge ap_clk);
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL order_drained: got %0d want 0", outstanding); end
      tick();
      idle();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset_mid();
      reset_dut();
      arready     = 1'b1;
      req_arvalid = 4'b0111;
      tick();
      tick();
      tick();
      req_arvalid = '0;
      @(negedge ap_clk);
      checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL rstmid_pre: got %0d want 3", outstanding); end
      tick();
      ap_rst_n = 1'b0;
      tick();
      ap_rst_n    = 1'b1;
      rvalid      = 1'b1;
      rlast       = 1'b1;
      req_rready  = '1;
      req_arvalid = '1;
      @(negedge ap_clk);
      checks++; if (arvalid !== 1'b0 || outstanding !== 3'd0) begin errors++; $display("FAIL rstmid_state: got %b/%0d want 0/0", arvalid, outstanding); end
      checks++; if (rready !== 1'b0 || req_rvalid !== 4'b0000) begin errors++; $display("FAIL rstmid_r: got %b/%b want 0/0000", rready, req_rvalid); end
      checks++; if (req_arready !== 4'b0001) begin errors++; $display("FAIL rstmid_priority: got %b want 0001", req_arready); end
      tick();
      idle();
   endtask

   // ---------------------------------------------------------------------------
   // Randomized run against a queue-based model: round-robin from last grant,
   // one AR slot, issue-ordered returns, at most MO bursts in flight.
   // ---------------------------------------------------------------------------
   task automatic test_random();
      bit            pend [NP];
      logic [AW-1:0] p_addr [NP];
      logic [7:0]    p_len [NP];
      burst_t        order_q [$];
      burst_t        gm_q [$];
      int            last_g, gm_beat, hp, win;
      bit            m_arv, gm_rv, has, e_rready, e_pop, e_grant;
      logic [AW-1:0] m_addr;
      logic [7:0]    m_len;
      logic [NP-1:0] e_rvalid, e_arready;

      reset_dut();
      last_g  = NP - 1;
      m_arv   = 1'b0;
      m_addr  = '0;
      m_len   = '0;
      gm_rv   = 1'b0;
      gm_beat = 0;
      for (int p = 0; p < NP; p++) begin
         pend[p]   = 1'b0;
         p_addr[p] = '0;
         p_len[p]  = '0;
      end

      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int p = 0; p < NP; p++) begin
            if (!pend[p] && $urandom_range(0, 2) == 0) begin
               pend[p]   = 1'b1;
               p_addr[p] = AW'({$urandom_range(0, 1023), $urandom});
               p_len[p]  = 8'($urandom_range(0, 3));
            end
            req_arvalid[p] = pend[p];
            addr_a[p]      = p_addr[p];
            len_a[p]       = p_len[p];
            req_rready[p]  = ($urandom_range(0, 3) != 0);
         end
         arready = ($urandom_range(0, 2) != 0);
         if (!gm_rv && gm_q.size() > 0 && $urandom_range(0, 1) == 1) gm_rv = 1'b1;
         rvalid = gm_rv;
         rdata  = '0;
         if (gm_rv) begin
            rdata[8 +: AW] = gm_q[0].addr;
            rdata[7:0]     = 8'(gm_beat);
            rlast          = (gm_beat == int'(gm_q[0].len));
         end else begin
            rlast = 1'($urandom_range(0, 1));
         end

         has       = (order_q.size() > 0);
         hp        = has ? int'(order_q[0].port) : 0;
         e_rready  = has && req_rready[hp];
         e_rvalid  = (has && gm_rv) ? (4'b0001 << hp) : 4'b0000;
         e_pop     = gm_rv && e_rready && rlast;
         win       = -1;
         for (int k = 1; k <= NP; k++)
            if (win < 0 && pend[(last_g + k) % NP]) win = (last_g + k) % NP;
         e_grant   = (!m_arv || arready) && (order_q.size() < MO || e_pop) && (win >= 0);
         e_arready = e_grant ? (4'b0001 << win) : 4'b0000;

         @(negedge ap_clk);
         checks++; if (req_arready !== e_arready) begin errors++; $display("FAIL rnd_arready cyc %0d: got %b want %b", cyc, req_arready, e_arready); end
         checks++; if (req_rvalid !== e_rvalid) begin errors++; $display("FAIL rnd_rvalid cyc %0d: got %b want %b", cyc, req_rvalid, e_rvalid); end
         checks++; if (rready !== e_rready) begin errors++; $display("FAIL rnd_rready cyc %0d: got %b want %b", cyc, rready, e_rready); end
         checks++; if (outstanding !== CW'(order_q.size())) begin errors++; $display("FAIL rnd_outstanding cyc %0d: got %0d want %0d", cyc, outstanding, order_q.size()); end
         checks++; if (arvalid !== m_arv) begin errors++; $display("FAIL rnd_arvalid cyc %0d: got %b want %b", cyc, arvalid, m_arv); end
         if (m_arv) begin
            checks++; if (araddr !== m_addr || arlen !== m_len) begin errors++; $display("FAIL rnd_ar cyc %0d: got %h/%0d want %h/%0d", cyc, araddr, arlen, m_addr, m_len); end
         end
         if (gm_rv && has) begin
            checks++; if (req_rdata[8 +: AW] !== order_q[0].addr || req_rlast !== rlast) begin errors++; $display("FAIL rnd_rdata cyc %0d: got %h want %h", cyc, req_rdata[8 +: AW], order_q[0].addr); end
         end

         if (gm_rv && e_rready) begin
            if (rlast) begin
               void'(gm_q.pop_front());
               void'(order_q.pop_front());
               gm_beat = 0;
            end else begin
               gm_beat++;
            end
            gm_rv = 1'b0;
         end
         if (m_arv && arready) begin
            gm_q.push_back('{port: 3'd0, addr: m_addr, len: m_len});
            m_arv = 1'b0;
         end
         if (e_grant) begin
            m_arv  = 1'b1;
            m_addr = p_addr[win];
            m_len  = p_len[win];
            order_q.push_back('{port: 3'(win), addr: p_addr[win], len: p_len[win]});
            pend[win] = 1'b0;
            last_g    = win;
         end
         tick();
      end
      idle();
   endtask

   initial begin
      ap_rst_n = 1'b0;
      idle();
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_full();
      test_order();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
